nios2_jtag_ocimem_arbiter: RTL and testbench
============================================

Name: nios2_jtag_ocimem_arbiter

Overview:
- Sequences JTAG debug accesses to the Nios II on-chip debug memory (OCI RAM) and shares that single-port RAM with the CPU debug-monitor port.
- Inputs: the sysclk-domain take_action_ocimem_a/b strobes and the jdo shift-register snapshot from the JTAG debug module.
- Outputs: RAM cycles, plus the MonDReg, monitor_ready and monitor_error status the tck-side scan chain reads back.
- Sits between the JTAG debug module wrapper and the OCI RAM, beside the CPU debug slave.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (256 x 32).
- DATA_W, 32, RAM data width. Fixed at 32 to match jdo[34:3].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read.
- take_action_ocimem_b  in  1  one-cycle strobe: write word.
- jdo  in  38  JTAG data-out snapshot, valid in the strobe cycle.
- cpu_req  in  1  CPU monitor request; held until cpu_gnt.
- cpu_we  in  1  CPU write enable, qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  access issued this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- ram_en  out  1  RAM cycle enable.
- ram_we  out  1  RAM write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_en & ~ram_we.
- MonDReg  out  DATA_W  last JTAG read data.
- monitor_ready  out  1  no JTAG operation pending or in flight.
- monitor_error  out  1  sticky JTAG overrun flag.

Behaviour:
- Reset values:
  - All outputs 0 except monitor_ready = 1.
  - Internal: jtag_addr = 0, pending = 0, last_winner = CPU, state = IDLE.
- Strobe decode, sampled at the clk edge:
  - ocimem_a: jtag_addr <= jdo[ADDR_W+25:26]. If jdo[35]==0, queue a read (pending=1, op=RD). If jdo[35]==1, address load only.
  - ocimem_b: queue a write (pending=1, op=WR, data=jdo[34:3]) at the current jtag_addr.
  - Both strobes in the same cycle: ocimem_a loads the address first, then ocimem_b writes to the new address. No read is queued.
  - A strobe that would queue while pending==1 or state!=IDLE is dropped and sets monitor_error=1. monitor_error clears only on reset or on ocimem_a with jdo[37]==1.
- monitor_ready = ~pending & (state==IDLE).
- FSM states: IDLE, JTAG_ACC, CPU_ACC, RD_WAIT.
- IDLE:
  - Only pending → JTAG_ACC.
  - Only cpu_req → CPU_ACC.
  - Both → the side that is not last_winner (round-robin).
  - Arbitration decision is registered, so a request presented in cycle N gets its RAM cycle in N+1 at the earliest.
- JTAG_ACC, one cycle:
  - Drives ram_en=1, ram_we=(op==WR), ram_addr=jtag_addr, ram_wdata.
  - Clears pending, sets last_winner=JTAG.
  - jtag_addr increments modulo 2^ADDR_W after every JTAG read or write (255→0).
  - Next state: RD_WAIT if read, else IDLE.
- CPU_ACC, one cycle:
  - Drives the RAM from the cpu_* inputs, cpu_gnt=1, sets last_winner=CPU.
  - Next state: RD_WAIT if ~cpu_we, else IDLE.
- RD_WAIT, one cycle:
  - Captures ram_rdata into MonDReg (JTAG) or cpu_rdata with cpu_rvalid=1 for that cycle (CPU).
  - Next state: IDLE.
- Latency, uncontested JTAG read, strobe in cycle N:
  - ram_en in N+2.
  - MonDReg valid and monitor_ready=1 from N+4.
- Latency, uncontested JTAG write, strobe in cycle N: ram_en in N+2, monitor_ready=1 from N+3.
- ram_en is never asserted in RD_WAIT or IDLE. There are no back-to-back RAM cycles.
- Reset mid-operation aborts immediately:
  - No RAM cycle in the cycle after reset.
  - A pending op is discarded.
  - MonDReg returns to 0.

Decomposition:
- Shared package nios2_oci_pkg holds:
  - state enum (IDLE, JTAG_ACC, CPU_ACC, RD_WAIT);
  - op enum (RD, WR);
  - jdo field constants: JDO_ADDR_LSB=26, JDO_RDN_BIT=35, JDO_CLRERR_BIT=37, JDO_DATA_LSB=3.
- One sub-module, nios2_oci_rr_arb2: a two-requester round-robin arbiter with a last_winner register.
- Strobe decode and the FSM stay in the top module.

Test Plan:
- Reset, then ocimem_a with jdo[33:26]=0x10, jdo[35]=1, then ocimem_b with jdo[34:3]=0xDEADBEEF → one RAM write at 0x10; jtag_addr becomes 0x11; monitor_ready returns high 3 cycles after the strobe.
- Preload RAM[0x10]=0x12345678; ocimem_a addr 0x10, jdo[35]=0 → ram_en at N+2; MonDReg=0x12345678 and monitor_ready=1 at N+4; jtag_addr=0x11.
- JTAG read strobe and cpu_req read of 0x20 asserted in the same cycle, last_winner=CPU → JTAG served first, CPU second; cpu_gnt and cpu_rvalid fire 3 cycles later than the JTAG cycle; in a repeat collision, CPU wins.
- Address 0xFF, two consecutive ocimem_b writes spaced 4 cycles → writes land at 0xFF then 0x00.
- Second ocimem_b one cycle after the first → second dropped, monitor_error=1; ocimem_a with jdo[37]=1 clears it to 0.
- Assert reset in the RD_WAIT cycle of a JTAG read → MonDReg=0, monitor_ready=1, no ram_en for at least one cycle.

Source files
------------

// File: rtl/nios2_oci_pkg.sv
// Shared types and jdo field positions for the OCI RAM JTAG arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package nios2_oci_pkg;

   typedef enum logic [1:0] {
      IDLE,
      JTAG_ACC,
      CPU_ACC,
      RD_WAIT
   } state_t;

   typedef enum logic {
      RD,
      WR
   } op_t;

   typedef enum logic {
      W_CPU,
      W_JTAG
   } winner_t;

   localparam int JDO_ADDR_LSB   = 26;
   localparam int JDO_RDN_BIT    = 35;
   localparam int JDO_CLRERR_BIT = 37;
   localparam int JDO_DATA_LSB   = 3;

endpackage

// File: rtl/nios2_oci_rr_arb2.sv
// Two-requester round-robin arbiter (JTAG vs CPU) with a last-winner register.
// Grants are combinational; the winner is remembered for the next collision.
module nios2_oci_rr_arb2
   import nios2_oci_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic req_jtag,
   input  logic req_cpu,
   output logic gnt_jtag,
   output logic gnt_cpu
);

   winner_t last_winner;

   assign gnt_jtag = en & req_jtag &
                     (~req_cpu | (last_winner == W_CPU));
   assign gnt_cpu  = en & req_cpu & ~gnt_jtag;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner <= W_CPU;
      end else if (gnt_jtag) begin
         last_winner <= W_JTAG;
      end else if (gnt_cpu) begin
         last_winner <= W_CPU;
      end
   end

endmodule

// File: rtl/nios2_jtag_ocimem_arbiter.sv
// Sequences JTAG debug accesses into the OCI RAM and shares the single
// RAM port with the CPU debug-monitor port.
module nios2_jtag_ocimem_arbiter
   import nios2_oci_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [37:0]       jdo,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   state_t            state;
   op_t               op;
   logic              pending;
   logic              rd_jtag;
   logic [ADDR_W-1:0] jtag_addr;
   logic [DATA_W-1:0] jtag_wdata;
   logic              gnt_jtag;
   logic              gnt_cpu;
   logic              queue_req;
   logic              busy;
   logic              drop;
   logic              accept;
   logic              unused_jdo;

   assign unused_jdo = ^{jdo[36], jdo[2:0]};

   // Address-only loads never queue, so only read/write strobes can overrun.
   assign queue_req = (take_action_ocimem_a & ~jdo[JDO_RDN_BIT]) |
                      take_action_ocimem_b;
   assign busy      = pending | (state != IDLE);
   assign drop      = queue_req & busy;
   assign accept    = queue_req & ~busy;

   assign monitor_ready = ~pending & (state == IDLE);

   nios2_oci_rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .en       (state == IDLE),
      .req_jtag (pending),
      .req_cpu  (cpu_req),
      .gnt_jtag (gnt_jtag),
      .gnt_cpu  (gnt_cpu)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         jtag_addr     <= '0;
         jtag_wdata    <= '0;
         op            <= RD;
         monitor_error <= 1'b0;
      end else begin
         if (take_action_ocimem_a & ~drop) begin
            jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
         end else if (state == JTAG_ACC) begin
            jtag_addr <= jtag_addr + 1'b1;
         end
         if (accept) begin
            op <= take_action_ocimem_b ? WR : RD;
         end
         if (accept & take_action_ocimem_b) begin
            jtag_wdata <= jdo[JDO_DATA_LSB +: DATA_W];
         end
         if (take_action_ocimem_a & jdo[JDO_CLRERR_BIT]) begin
            monitor_error <= 1'b0;
         end
         if (drop) begin
            monitor_error <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pending    <= 1'b0;
         rd_jtag    <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         cpu_gnt    <= 1'b0;
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         MonDReg    <= '0;
      end else begin
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         cpu_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         if (accept) begin
            pending <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (gnt_jtag) begin
                  state     <= JTAG_ACC;
                  rd_jtag   <= 1'b1;
                  ram_en    <= 1'b1;
                  ram_we    <= (op == WR);
                  ram_addr  <= jtag_addr;
                  ram_wdata <= jtag_wdata;
               end else if (gnt_cpu) begin
                  state     <= CPU_ACC;
                  rd_jtag   <= 1'b0;
                  ram_en    <= 1'b1;
                  ram_we    <= cpu_we;
                  ram_addr  <= cpu_addr;
                  ram_wdata <= cpu_wdata;
                  cpu_gnt   <= 1'b1;
               end
            end
            JTAG_ACC: begin
               pending <= 1'b0;
               state   <= ram_we ? IDLE : RD_WAIT;
            end
            CPU_ACC: begin
               state <= ram_we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               if (rd_jtag) begin
                  MonDReg <= ram_rdata;
               end else begin
                  cpu_rdata  <= ram_rdata;
                  cpu_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_jtag_ocimem_arbiter.sv
// Directed bench for the OCI RAM JTAG arbiter with a behavioural RAM.
// Vector table for strobe/write flows, hand sequences for arbitration and reset.
module tb_nios2_jtag_ocimem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        take_action_ocimem_a = 1'b0;
   logic        take_action_ocimem_b = 1'b0;
   logic [37:0] jdo = '0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_gnt;
   logic [31:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        ram_en;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;

   logic [31:0] mem [256];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nios2_jtag_ocimem_arbiter dut (
      .clk                  (clk),
      .reset                (reset),
      .take_action_ocimem_a (take_action_ocimem_a),
      .take_action_ocimem_b (take_action_ocimem_b),
      .jdo                  (jdo),
      .cpu_req              (cpu_req),
      .cpu_we               (cpu_we),
      .cpu_addr             (cpu_addr),
      .cpu_wdata            (cpu_wdata),
      .cpu_gnt              (cpu_gnt),
      .cpu_rdata            (cpu_rdata),
      .cpu_rvalid           (cpu_rvalid),
      .ram_en               (ram_en),
      .ram_we               (ram_we),
      .ram_addr             (ram_addr),
      .ram_wdata            (ram_wdata),
      .ram_rdata            (ram_rdata),
      .MonDReg              (MonDReg),
      .monitor_ready        (monitor_ready),
      .monitor_error        (monitor_error)
   );

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
   end

   typedef struct {
      logic        a;
      logic        b;
      logic [37:0] jdo;
      logic        en;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic        rdy;
      logic        err;
      logic [7:0]  jaddr;
   } vec_t;

   vec_t tv [15];

   function automatic logic [37:0] jdo_a(input logic clr, input logic rdn,
                                         input logic [7:0] addr);
      logic [37:0] j;
      j = '0;
      j[37] = clr;
      j[35] = rdn;
      j[33:26] = addr;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      logic [37:0] j;
      j = '0;
      j[34:3] = d;
      return j;
   endfunction

   function automatic vec_t mkv(input logic a, input logic b,
                                input logic [37:0] j, input logic en,
                                input logic [7:0] addr, input logic [31:0] wd,
                                input logic rdy, input logic err,
                                input logic [7:0] jaddr);
      vec_t v;
      v.a = a; v.b = b; v.jdo = j; v.en = en; v.we = en;
      v.addr = addr; v.wd = wd; v.rdy = rdy; v.err = err; v.jaddr = jaddr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int i;
      for (i = 0; i < 12; i++) begin
         if (monitor_ready) break;
         step();
      end
      chk("wait_ready", {63'd0, monitor_ready}, 64'd1);
   endtask

   task automatic cpu_access(input logic we, input logic [7:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic ok);
      logic got;
      got = 1'b0;
      rd = '0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (cpu_gnt) got = 1'b1;
      end
      cpu_req = 1'b0;
      if (!we && got) begin
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (cpu_rvalid) begin
               got = 1'b1;
               rd = cpu_rdata;
            end
         end
      end
      ok = got;
   endtask

   task automatic collide(input logic [7:0] jaddr, input logic [7:0] caddr,
                          output int jc, output int gc, output int rc,
                          output logic [7:0] ja, output logic [7:0] ga,
                          output logic [31:0] rd);
      jc = -1; gc = -1; rc = -1; ja = '0; ga = '0; rd = '0;
      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b0, 1'b0, jaddr);
      for (int c = 1; c <= 10; c++) begin
         step();
         if (ram_en && !cpu_gnt && jc < 0) begin
            jc = c; ja = ram_addr;
         end
         if (cpu_gnt) begin
            gc = c; ga = ram_addr; cpu_req = 1'b0;
         end
         if (cpu_rvalid) begin
            rc = c; rd = cpu_rdata;
         end
         if (c == 1) begin
            take_action_ocimem_a = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = caddr;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic ok;
      int jc, gc, rc;
      logic [7:0] ja, ga;

      tv[0]  = mkv(1, 0, jdo_a(0, 1, 8'h10), 0, 8'h00, 32'h0, 1, 0, 8'h10);
      tv[1]  = mkv(0, 1, jdo_b(32'hDEADBEEF), 0, 8'h00, 32'h0, 0, 0, 8'h10);
      tv[2]  = mkv(0, 0, '0, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h10);
      tv[3]  = mkv(0, 0, '0, 0, 8'h00, 32'h0, 1, 0, 8'h11);
      tv[4]  = mkv(0, 1, jdo_b(32'h1), 0, 8'h00, 32'h0, 0, 0, 8'h11);
      tv[5]  = mkv(0, 1, jdo_b(32'h2), 1, 8'h11, 32'h1, 0, 1, 8'h11);
      tv[6]  = mkv(0, 0, '0, 0, 8'h00, 32'h0, 1, 1, 8'h12);
      tv[7]  = mkv(1, 0, jdo_a(1, 1, 8'hFF), 0, 8'h00, 32'h0, 1, 0, 8'hFF);
      tv[8]  = mkv(0, 1, jdo_b(32'hA), 0, 8'h00, 32'h0, 0, 0, 8'hFF);
      tv[9]  = mkv(0, 0, '0, 1, 8'hFF, 32'hA, 0, 0, 8'hFF);
      tv[10] = mkv(0, 0, '0, 0, 8'h00, 32'h0, 1, 0, 8'h00);
      tv[11] = mkv(0, 0, '0, 0, 8'h00, 32'h0, 1, 0, 8'h00);
      tv[12] = mkv(0, 1, jdo_b(32'hB), 0, 8'h00, 32'h0, 0, 0, 8'h00);
      tv[13] = mkv(0, 0, '0, 1, 8'h00, 32'hB, 0, 0, 8'h00);
      tv[14] = mkv(0, 0, '0, 0, 8'h00, 32'h0, 1, 0, 8'h01);

      step();
      step();
      reset = 1'b0;
      chk("rst_ram_en", {63'd0, ram_en}, 64'd0);
      chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
      chk("rst_rvalid", {63'd0, cpu_rvalid}, 64'd0);
      chk("rst_mondreg", {32'd0, MonDReg}, 64'd0);
      chk("rst_ready", {63'd0, monitor_ready}, 64'd1);
      chk("rst_error", {63'd0, monitor_error}, 64'd0);
      chk("rst_ram_addr", {56'd0, ram_addr}, 64'd0);

      for (int i = 0; i < 15; i++) begin
         take_action_ocimem_a = tv[i].a;
         take_action_ocimem_b = tv[i].b;
         jdo = tv[i].jdo;
         step();
         chk($sformatf("v%0d_en", i), {63'd0, ram_en}, {63'd0, tv[i].en});
         chk($sformatf("v%0d_rdy", i), {63'd0, monitor_ready},
             {63'd0, tv[i].rdy});
         chk($sformatf("v%0d_err", i), {63'd0, monitor_error},
             {63'd0, tv[i].err});
         chk($sformatf("v%0d_jaddr", i), {56'd0, dut.jtag_addr},
             {56'd0, tv[i].jaddr});
         if (tv[i].en) begin
            chk($sformatf("v%0d_we", i), {63'd0, ram_we}, {63'd0, tv[i].we});
            chk($sformatf("v%0d_addr", i), {56'd0, ram_addr},
                {56'd0, tv[i].addr});
            chk($sformatf("v%0d_wd", i), {32'd0, ram_wdata},
                {32'd0, tv[i].wd});
         end
      end
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      jdo = '0;
      step();
      chk("mem_10", {32'd0, mem[8'h10]}, 64'hDEADBEEF);
      chk("mem_ff", {32'd0, mem[8'hFF]}, 64'hA);
      chk("mem_00", {32'd0, mem[8'h00]}, 64'hB);

      wait_ready();
      cpu_access(1'b1, 8'h20, 32'hCAFE0020, rd, ok);
      chk("cpu_wr20_ok", {63'd0, ok}, 64'd1);
      wait_ready();
      cpu_access(1'b1, 8'h10, 32'h12345678, rd, ok);
      chk("cpu_wr10_ok", {63'd0, ok}, 64'd1);
      wait_ready();
      step();
      chk("cpu_wr10_mem", {32'd0, mem[8'h10]}, 64'h12345678);

      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b0, 1'b0, 8'h10);
      step();
      take_action_ocimem_a = 1'b0;
      chk("rd_n1_en", {63'd0, ram_en}, 64'd0);
      step();
      chk("rd_n2_en", {63'd0, ram_en}, 64'd1);
      chk("rd_n2_we", {63'd0, ram_we}, 64'd0);
      chk("rd_n2_addr", {56'd0, ram_addr}, 64'h10);
      step();
      chk("rd_n3_ready", {63'd0, monitor_ready}, 64'd0);
      step();
      chk("rd_n4_ready", {63'd0, monitor_ready}, 64'd1);
      chk("rd_n4_mondreg", {32'd0, MonDReg}, 64'h12345678);
      chk("rd_n4_jaddr", {56'd0, dut.jtag_addr}, 64'h11);

      cpu_access(1'b0, 8'h10, 32'h0, rd, ok);
      chk("cpu_rd_ok", {63'd0, ok}, 64'd1);
      chk("cpu_rd_data", {32'd0, rd}, 64'h12345678);
      wait_ready();

      collide(8'h10, 8'h20, jc, gc, rc, ja, ga, rd);
      chk("c1_jtag_cyc", 64'(jc), 64'd2);
      chk("c1_jtag_addr", {56'd0, ja}, 64'h10);
      chk("c1_gnt_cyc", 64'(gc), 64'd5);
      chk("c1_gnt_addr", {56'd0, ga}, 64'h20);
      chk("c1_rvalid_cyc", 64'(rc), 64'd7);
      chk("c1_rdata", {32'd0, rd}, 64'hCAFE0020);
      chk("c1_mondreg", {32'd0, MonDReg}, 64'h12345678);
      wait_ready();

      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b0, 1'b1, 8'h30);
      step();
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b1;
      jdo = jdo_b(32'h0BADF00D);
      step();
      take_action_ocimem_b = 1'b0;
      step();
      wait_ready();
      chk("w30_mem", {32'd0, mem[8'h30]}, 64'h0BADF00D);

      collide(8'h30, 8'h20, jc, gc, rc, ja, ga, rd);
      chk("c2_gnt_cyc", 64'(gc), 64'd2);
      chk("c2_gnt_addr", {56'd0, ga}, 64'h20);
      chk("c2_rvalid_cyc", 64'(rc), 64'd4);
      chk("c2_rdata", {32'd0, rd}, 64'hCAFE0020);
      chk("c2_jtag_cyc", 64'(jc), 64'd5);
      chk("c2_jtag_addr", {56'd0, ja}, 64'h30);
      chk("c2_mondreg", {32'd0, MonDReg}, 64'h0BADF00D);
      wait_ready();

      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b0, 1'b0, 8'h10);
      step();
      take_action_ocimem_a = 1'b0;
      step();
      chk("rr_n2_en", {63'd0, ram_en}, 64'd1);
      step();
      chk("rr_n3_ready", {63'd0, monitor_ready}, 64'd0);
      reset = 1'b1;
      step();
      chk("rr_mondreg", {32'd0, MonDReg}, 64'd0);
      chk("rr_ready", {63'd0, monitor_ready}, 64'd1);
      chk("rr_en", {63'd0, ram_en}, 64'd0);
      chk("rr_rvalid", {63'd0, cpu_rvalid}, 64'd0);
      reset = 1'b0;
      step();
      chk("rr_post_en", {63'd0, ram_en}, 64'd0);

      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b0, 1'b0, 8'h10);
      step();
      take_action_ocimem_a = 1'b0;
      chk("rp_pending_ready", {63'd0, monitor_ready}, 64'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rp_en%0d", i), {63'd0, ram_en}, 64'd0);
         chk($sformatf("rp_ready%0d", i), {63'd0, monitor_ready}, 64'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
